// File: rtl/pmem_initiator.sv
// Byte-serial memory initiator: turns one byte/word read/write request into one
// or two memory beats, with a per-beat wait timeout. All outputs are registered.
module pmem_initiator #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic        req_data,
  input  logic        req_word,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        mem_select,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_type_data,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

  state_t      state, state_n;
  logic        beat, beat_n;
  logic [7:0]  cnt, cnt_n;
  logic        lat_write, lat_write_n;
  logic        lat_data, lat_data_n;
  logic        lat_word, lat_word_n;
  logic [7:0]  lat_addr, lat_addr_n;
  logic [15:0] lat_wdata, lat_wdata_n;
  logic [15:0] rdata_n;
  logic        err_n;

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    cnt_n       = cnt;
    lat_write_n = lat_write;
    lat_data_n  = lat_data;
    lat_word_n  = lat_word;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    rdata_n     = rdata;
    err_n       = err;
    case (state)
      IDLE: begin
        if (req) begin
          lat_write_n = req_write;
          lat_data_n  = req_data;
          lat_word_n  = req_word;
          lat_addr_n  = req_addr;
          lat_wdata_n = req_wdata;
          beat_n      = 1'b0;
          cnt_n       = '0;
          rdata_n     = '0;
          err_n       = 1'b0;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (!lat_write) begin
            if (beat) rdata_n[15:8] = mem_rdata;
            else      rdata_n[7:0]  = mem_rdata;
          end
          state_n = (lat_word && !beat) ? GAP : DONE;
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == TIMEOUT_CNT) begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      GAP: begin
        beat_n  = 1'b1;
        cnt_n   = '0;
        state_n = ACCESS;
      end
      DONE: begin
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory-side outputs are derived from the next-state values so they change
  // on the same edge as the state, keeping every output a plain flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= 1'b0;
      cnt           <= '0;
      lat_write     <= 1'b0;
      lat_data      <= 1'b0;
      lat_word      <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      ack           <= 1'b0;
      mem_select    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_type_data <= 1'b0;
      mem_write     <= 1'b0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      cnt           <= cnt_n;
      lat_write     <= lat_write_n;
      lat_data      <= lat_data_n;
      lat_word      <= lat_word_n;
      lat_addr      <= lat_addr_n;
      lat_wdata     <= lat_wdata_n;
      rdata         <= rdata_n;
      err           <= err_n;
      busy          <= (state_n != IDLE);
      ack           <= (state_n == DONE);
      mem_select    <= (state_n == ACCESS);
      mem_addr      <= lat_addr_n + {7'd0, beat_n};
      mem_wdata     <= beat_n ? lat_wdata_n[15:8] : lat_wdata_n[7:0];
      mem_type_data <= lat_data_n;
      mem_write     <= (state_n == ACCESS) && lat_write_n;
    end
  end

endmodule
